// File: rtl/plic_arbiter.sv
// Interrupt gateway and priority arbiter: per-source IDLE/PENDING/INFLIGHT
// gateways, per-source priority registers, and a registered claim/complete handshake.
module plic_arbiter #(
  parameter int NSRC   = 4,
  parameter int PRIO_W = 3,
  parameter int IDW    = $clog2(NSRC + 1)
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              prio_we,
  input  logic [IDW-1:0]    prio_idx,
  input  logic [PRIO_W-1:0] prio_wdata,
  input  logic [PRIO_W-1:0] threshold,
  input  logic              claim,
  input  logic              complete,
  input  logic [IDW-1:0]    complete_id,
  output logic              irq_out,
  output logic [IDW-1:0]    claim_id,
  output logic              claim_valid
);

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_INFLIGHT
  } gw_state_t;

  logic [NSRC-1:0]              pending;
  logic [NSRC-1:0][PRIO_W-1:0]  prio_flat;
  logic [IDW-1:0]               winner;
  logic [PRIO_W-1:0]            win_prio;
  logic [IDW-1:0]               grant_id;
  logic                         best_pending;
  logic [IDW-1:0]               best_id_reg;
  logic                         irq_out_reg;
  logic [IDW-1:0]               claim_id_reg;
  logic                         claim_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      localparam logic [IDW-1:0] SRC_ID = IDW'(gi + 1);
      gw_state_t         state_reg;
      gw_state_t         state_next;
      logic [PRIO_W-1:0] prio_reg;

      always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
          state_reg <= GW_IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // INFLIGHT ignores the request level; a held line re-pends via IDLE.
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          GW_IDLE:     if (irq_src[gi]) state_next = GW_PENDING;
          GW_PENDING:  if (grant_id == SRC_ID) state_next = GW_INFLIGHT;
          GW_INFLIGHT: if (complete && complete_id == SRC_ID) state_next = GW_IDLE;
          default:     state_next = GW_IDLE;
        endcase
      end

      always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
          prio_reg <= '0;
        end else if (prio_we && prio_idx == SRC_ID) begin
          prio_reg <= prio_wdata;
        end
      end

      assign pending[gi]   = (state_reg == GW_PENDING);
      assign prio_flat[gi] = prio_reg;
    end
  endgenerate

  // Strict '>' keeps the lowest ID on ties; threshold >= 0 also excludes priority 0.
  always_comb begin
    winner   = '0;
    win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i] && prio_flat[i] > threshold && prio_flat[i] > win_prio) begin
        winner   = IDW'(i + 1);
        win_prio = prio_flat[i];
      end
    end
  end

  // A stale best_id (already granted by the previous claim) must not be granted twice.
  always_comb begin
    best_pending = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (best_id_reg == IDW'(i + 1) && pending[i]) best_pending = 1'b1;
    end
    grant_id = (claim && best_pending) ? best_id_reg : '0;
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      best_id_reg     <= '0;
      irq_out_reg     <= 1'b0;
      claim_id_reg    <= '0;
      claim_valid_reg <= 1'b0;
    end else begin
      best_id_reg     <= winner;
      irq_out_reg     <= (winner != '0);
      claim_valid_reg <= claim;
      if (claim) claim_id_reg <= grant_id;
    end
  end

  assign irq_out     = irq_out_reg;
  assign claim_id    = claim_id_reg;
  assign claim_valid = claim_valid_reg;

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed bench for plic_arbiter: request latency, claim/complete, ties,
// threshold, back-to-back claims and asynchronous reset.
module tb_plic_arbiter;
  localparam int NSRC   = 4;
  localparam int PRIO_W = 3;
  localparam int IDW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NSRC-1:0]   irq_src;
  logic              prio_we;
  logic [IDW-1:0]    prio_idx;
  logic [PRIO_W-1:0] prio_wdata;
  logic [PRIO_W-1:0] threshold;
  logic              claim;
  logic              complete;
  logic [IDW-1:0]    complete_id;
  logic              irq_out;
  logic [IDW-1:0]    claim_id;
  logic              claim_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plic_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W), .IDW(IDW)) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .irq_src    (irq_src),
    .prio_we    (prio_we),
    .prio_idx   (prio_idx),
    .prio_wdata (prio_wdata),
    .threshold  (threshold),
    .claim      (claim),
    .complete   (complete),
    .complete_id(complete_id),
    .irq_out    (irq_out),
    .claim_id   (claim_id),
    .claim_valid(claim_valid)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_prio(input int idx, input int data);
    prio_we    = 1'b1;
    prio_idx   = IDW'(idx);
    prio_wdata = PRIO_W'(data);
    step();
    prio_we    = 1'b0;
  endtask

  task automatic do_claim();
    claim = 1'b1;
    step();
    claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete    = 1'b1;
    complete_id = IDW'(id);
    step();
    complete    = 1'b0;
  endtask

  initial begin
    irq_src = '0; prio_we = 1'b0; prio_idx = '0; prio_wdata = '0;
    threshold = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;

    // Reset and single request with latency
    #1 rst = 1'b1;
    #1;
    check_value("rst_irq_out", irq_out, 0);
    check_value("rst_claim_id", claim_id, 0);
    check_value("rst_claim_valid", claim_valid, 0);
    irq_src = 4'b0010;
    step(); step();
    check_value("rst_hold_irq", irq_out, 0);
    rst = 1'b0;
    wr_prio(2, 3);
    check_value("req_lat_1", irq_out, 0);
    step();
    check_value("req_lat_2", irq_out, 1);
    do_claim();
    check_value("claim2_id", claim_id, 2);
    check_value("claim2_valid", claim_valid, 1);
    check_value("claim2_irq_k", irq_out, 1);
    step();
    check_value("claim2_irq_k1", irq_out, 0);
    check_value("claim2_pulse_end", claim_valid, 0);

    // Wrong-ID completion ignored, correct one re-pends a held line
    do_complete(3);
    step();
    check_value("wrong_cmp", irq_out, 0);
    do_complete(2);
    check_value("cmp_idle", irq_out, 0);
    step();
    check_value("cmp_pending", irq_out, 0);
    step();
    check_value("cmp_repend", irq_out, 1);
    do_claim();
    check_value("reclaim2_id", claim_id, 2);
    irq_src = 4'b0000;
    do_complete(2);
    step();
    check_value("cleared", irq_out, 0);

    // Priority ordering with tie on 3/4
    wr_prio(1, 2); wr_prio(3, 5); wr_prio(4, 5); wr_prio(5, 7);
    irq_src = 4'b1101;
    step(); step();
    check_value("tie_irq", irq_out, 1);
    do_claim();
    check_value("tie_c1", claim_id, 3);
    step();
    do_claim();
    check_value("tie_c2", claim_id, 4);
    step();
    do_claim();
    check_value("tie_c3", claim_id, 1);
    step();
    check_value("tie_irq_done", irq_out, 0);
    do_claim();
    check_value("tie_c4", claim_id, 0);
    check_value("tie_c4_valid", claim_valid, 1);
    irq_src = 4'b0000;
    do_complete(1); do_complete(3); do_complete(4);

    // Threshold gating
    threshold = 3'd4;
    irq_src   = 4'b0001;
    wr_prio(1, 4);
    step();
    check_value("thr_block_1", irq_out, 0);
    step();
    check_value("thr_block_2", irq_out, 0);
    threshold = 3'd3;
    step();
    check_value("thr_rise", irq_out, 1);
    do_claim();
    check_value("thr_claim", claim_id, 1);

    // Back-to-back claims with only ID 1 pending
    do_complete(1);
    step();
    step();
    check_value("b2b_irq", irq_out, 1);
    claim = 1'b1;
    step();
    check_value("b2b_1_id", claim_id, 1);
    check_value("b2b_1_valid", claim_valid, 1);
    step();
    claim = 1'b0;
    check_value("b2b_2_id", claim_id, 0);
    check_value("b2b_2_valid", claim_valid, 1);
    step();
    check_value("b2b_end_valid", claim_valid, 0);

    // Reset with ID 2 INFLIGHT and ID 3 PENDING
    threshold = 3'd0;
    irq_src   = 4'b0010;
    step(); step();
    irq_src = 4'b0110;
    do_claim();
    check_value("pre_rst_claim", claim_id, 2);
    #2 rst = 1'b1;
    #1;
    check_value("mid_rst_irq", irq_out, 0);
    check_value("mid_rst_id", claim_id, 0);
    check_value("mid_rst_valid", claim_valid, 0);
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check_value("post_rst_irq", irq_out, 0);
    do_claim();
    check_value("post_rst_claim", claim_id, 0);
    check_value("post_rst_valid", claim_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
